// File: rtl/div_ratio_monitor.sv
// Measures period and high time of a divided clock in iClkIN cycles, classifies
// the division ratio, tracks lock over consecutive matching periods, and flags loss.
module div_ratio_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic             reset,
  input  logic             iClkIN,
  input  logic             iDivClk,
  output logic [CNT_W-1:0] oPeriod,
  output logic [2:0]       oRatio,
  output logic             oValid,
  output logic             oLocked,
  output logic             oLoss
);

  localparam int unsigned       MC_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s, s_d;
  logic                   rise_c, timeout_c, same_c;
  logic [CNT_W-1:0]       pcnt, hcnt;
  logic [2:0]             code_c;
  logic [MC_W-1:0]        match_q, match_nxt, match_inc_c;
  logic [CNT_W-1:0]       period_nxt;
  logic [2:0]             ratio_nxt;
  logic                   valid_nxt, locked_nxt, loss_nxt;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_s & ~s_d;

  // Synchronizer chain plus one-cycle delay for edge detection
  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iDivClk};
      s_d    <= sync_s;
    end
  end

  // Period and high-time counters; the rise cycle itself counts as cycle 1
  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (rise_c) begin
      pcnt <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else begin
      if (pcnt != CNT_MAX) pcnt <= pcnt + CNT_W'(1);
      if (sync_s && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_W'(1);
    end
  end

  // Ratio code for the period just completed; requires exact 50% duty
  always_comb begin
    code_c = 3'd0;
    if ({hcnt, 1'b0} == {1'b0, pcnt}) begin
      case (pcnt)
        CNT_W'(2):  code_c = 3'd1;
        CNT_W'(4):  code_c = 3'd2;
        CNT_W'(8):  code_c = 3'd3;
        CNT_W'(16): code_c = 3'd4;
        default:    code_c = 3'd0;
      endcase
    end
  end

  assign timeout_c   = (state_q != IDLE) && !rise_c && (pcnt == CNT_W'(TIMEOUT));
  assign same_c      = (code_c == oRatio) && ((state_q == TRACK) || (state_q == LOCKED));
  assign match_inc_c = (match_q >= MC_W'(LOCK_COUNT)) ? match_q : match_q + MC_W'(1);

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (timeout_c) begin
      state_nxt = IDLE;
    end else if (rise_c) begin
      if (state_q == IDLE)
        state_nxt = ARMED;
      else if (code_c == 3'd0)
        state_nxt = ARMED;
      else if (same_c)
        state_nxt = (match_inc_c >= MC_W'(LOCK_COUNT)) ? LOCKED : TRACK;
      else
        state_nxt = (LOCK_COUNT == 1) ? LOCKED : TRACK;
    end
  end

  // Next values of the registered outputs and match count
  always_comb begin
    period_nxt = oPeriod;
    ratio_nxt  = oRatio;
    valid_nxt  = 1'b0;
    locked_nxt = oLocked;
    loss_nxt   = oLoss;
    match_nxt  = match_q;
    if (timeout_c) begin
      loss_nxt   = 1'b1;
      locked_nxt = 1'b0;
      ratio_nxt  = 3'd0;
      match_nxt  = '0;
    end else if (rise_c) begin
      loss_nxt   = 1'b0;
      locked_nxt = (state_nxt == LOCKED);
      if (state_q != IDLE) begin
        period_nxt = pcnt;
        ratio_nxt  = code_c;
        valid_nxt  = 1'b1;
        if (code_c == 3'd0) match_nxt = '0;
        else if (same_c)    match_nxt = match_inc_c;
        else                match_nxt = MC_W'(1);
      end
    end
  end

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      oPeriod <= '0;
      oRatio  <= 3'd0;
      oValid  <= 1'b0;
      oLocked <= 1'b0;
      oLoss   <= 1'b0;
      match_q <= '0;
    end else begin
      oPeriod <= period_nxt;
      oRatio  <= ratio_nxt;
      oValid  <= valid_nxt;
      oLocked <= locked_nxt;
      oLoss   <= loss_nxt;
      match_q <= match_nxt;
    end
  end

endmodule

// File: doc/div_ratio_monitor.md
Name: div_ratio_monitor

Overview:
Receive-side companion to the team's divided-clock generator. Takes one divided-clock line (div2/4/8/16 nominal), samples it in the iClkIN domain and measures its period and high time in iClkIN cycles. Classifies the division ratio, declares lock after repeated consistent measurements, and flags loss of the divided clock. Sits at the consumer end of the divided-clock outputs, for system health reporting and mode checking.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on iDivClk (min 2)
LOCK_COUNT, 4, consecutive matching valid periods required to assert oLocked (1..15)
TIMEOUT, 64, iClkIN cycles without a rising edge before loss is declared (>16, <2^CNT_W)
CNT_W, 7, width of period/high-time counters

Ports:
reset  input  1  asynchronous, active-low
iClkIN  input  1  reference clock, all logic on posedge
iDivClk  input  1  divided clock under test, treated as asynchronous
oPeriod  output  CNT_W  last measured period, in iClkIN cycles
oRatio  output  3  0=none/invalid, 1=div2, 2=div4, 3=div8, 4=div16
oValid  output  1  one-cycle pulse when oPeriod/oRatio update
oLocked  output  1  level, ratio stable for LOCK_COUNT periods
oLoss  output  1  level, no rising edge within TIMEOUT cycles

Behaviour:
- Reset (reset=0, async): sync chain, counters and match count cleared; FSM=IDLE; oPeriod=0, oRatio=0, oValid=0, oLocked=0, oLoss=0.
- Sync: iDivClk through SYNC_STAGES flops -> s; s_d = s delayed one cycle. rise = s & ~s_d. Input-to-rise latency = SYNC_STAGES+1 cycles.
- pcnt: on rise cycle loads 1; otherwise increments, saturating at 2^CNT_W-1.
- hcnt: on rise cycle loads 1; otherwise increments when s=1, saturating.
- At a rise, measurement P = pcnt, H = hcnt (values before reload). Valid iff P in {2,4,8,16} and H == P/2. Code per oRatio table; invalid -> code 0.
- FSM:
  IDLE: wait for rise -> ARMED. No measurement (previous edge unknown).
  ARMED: at rise, oPeriod<=P, oRatio<=code, oValid pulse; if code!=0 then match count=1, go TRACK, else stay ARMED.
  TRACK: at rise, publish P/code, oValid pulse. Same nonzero code: match count+1; at LOCK_COUNT -> LOCKED, oLocked=1 in the same update cycle. Different nonzero code: match count=1, stay TRACK. Code 0: -> ARMED, match count=0.
  LOCKED: at rise, publish; same code: stay. Any other code: oLocked=0 next cycle, -> ARMED (code 0) or TRACK with match count=1 (new nonzero code).
- LOCK_COUNT=1: ARMED jumps directly to LOCKED on first valid measurement.
- Loss: in any state except IDLE, pcnt reaching TIMEOUT -> oLoss=1, oLocked=0, oRatio=0, match count=0, -> IDLE. oLoss stays 1 until the next rise, cleared on that rise cycle. In IDLE after reset, oLoss is not asserted (no clock yet seen).
- Simultaneous rise and pcnt==TIMEOUT: rise wins; no loss declared.
- oValid only ever high for exactly one cycle per rise outside IDLE.
- oPeriod holds last published value; loss does not clear it.
- Reset mid-operation: immediate return to reset values; next lock requires full IDLE->ARMED->TRACK sequence.

Test Plan:
- Reset: drive iDivClk toggling, hold reset=0 -> all outputs 0, no oValid; release -> first oValid on 2nd observed rise.
- div4 stable: iDivClk = iClkIN/4, 50% duty, LOCK_COUNT=4 -> oPeriod=4, oRatio=2 on each oValid; oLocked rises on 4th valid measurement; oLoss=0.
- Sweep ratios: div2, div8, div16 in turn (each held 10 periods) -> oRatio 1, 3, 4; oPeriod 2, 8, 16; oLocked drops on each change, relocks after 4 periods.
- Bad duty: period 8, high 3 cycles -> oPeriod=8, oRatio=0, oLocked never asserts; restore 4/4 duty -> lock after 4 periods.
- Loss: lock on div16, then hold iDivClk=0 -> oLoss=1 and oLocked=0 exactly when pcnt hits 64; restart div16 -> oLoss clears on first rise, relock after 1+4 rises.
- Async reset mid-TRACK (after 2 matches) -> outputs cleared at once; after release, lock takes full 5 rises.
